pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage core: the consumer of the hazard requests produced by the forwarding unit and by the branch/jump/memory logic. It resolves competing requests by priority and turns them into per-stage enable and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also sequences multi-cycle data-memory waits, halt, and a memory-timeout trap through a small registered FSM.

---
 rtl/pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: prioritises hazard requests into per-stage enables/flushes and
// sequences memory waits, halt and the memory-timeout trap. Optional macro: PIPE_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Need_Stall,
  input  logic        EX__Branch_Taken,
  input  logic        ID__Jump,
  input  logic        MEM__Req,
  input  logic        MEM__Ready,
  input  logic        WB__Halt,
  input  logic        Resume,
  output logic        PC_En,
  output logic        IFid_En,
  output logic        IDex_En,
  output logic        EXmem_En,
  output logic        MEMwb_En,
  output logic        IFid_Flush,
  output logic        IDex_Flush,
  output logic        EXmem_Flush,
  output logic [1:0]  PC_Src,
  output logic        Stalled,
  output logic        Mem_Timeout,
  output logic [31:0] Perf_Stall_Cnt,
  output logic [31:0] Perf_Flush_Cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PERF_W  = 32;
  localparam int unsigned EN_W    = 5;
  localparam int unsigned FLUSH_W = 3;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Enable order {PC, IF/ID, ID/EX, EX/MEM, MEM/WB}; flush order {IF/ID, ID/EX, EX/MEM}.
  localparam logic [EN_W-1:0]    EN_ALL     = '1;
  localparam logic [EN_W-1:0]    EN_LOADUSE = 5'b00011;
  localparam logic [FLUSH_W-1:0] FL_LOADUSE = 3'b001;
  localparam logic [FLUSH_W-1:0] FL_BRANCH  = 3'b110;
  localparam logic [FLUSH_W-1:0] FL_JUMP    = 3'b100;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [EN_W-1:0]    en_c;
  logic [FLUSH_W-1:0] flush_c;
  logic [1:0]         pc_src_c;
  logic               stalled_c;
  logic               prio_eval_c;
  logic               mem_wait_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    en_c        = EN_ALL;
    flush_c     = '0;
    pc_src_c    = 2'b00;
    prio_eval_c = 1'b0;
    mem_wait_c  = (state_q == ST_RUN) && MEM__Req && !MEM__Ready;

    case (state_q)
      ST_RUN: prio_eval_c = 1'b1;
      ST_MWAIT: begin
        if (!MEM__Ready) begin
          en_c  = '0;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (cnt_q == TIMEOUT_VAL) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end
        end else begin
          prio_eval_c = 1'b1;
        end
      end
      ST_HALT: begin
        en_c  = '0;
        cnt_d = '0;
        if (Resume) begin
          state_d   = ST_RUN;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Shared priority list; the memory-wait term is only live from RUN.
    if (prio_eval_c) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      if (WB__Halt) begin
        en_c    = '0;
        state_d = ST_HALT;
      end else if (mem_wait_c) begin
        en_c    = '0;
        state_d = ST_MWAIT;
        cnt_d   = CNT_W'(1);
      end else if (Need_Stall) begin
        en_c    = EN_LOADUSE;
        flush_c = FL_LOADUSE;
      end else if (EX__Branch_Taken) begin
        pc_src_c = 2'b10;
        flush_c  = FL_BRANCH;
      end else if (ID__Jump) begin
        pc_src_c = 2'b01;
        flush_c  = FL_JUMP;
      end
    end

    if (!rst) begin
      en_c     = '0;
      flush_c  = '0;
      pc_src_c = 2'b00;
    end
    stalled_c = rst && (en_c != EN_ALL);
  end

  assign {PC_En, IFid_En, IDex_En, EXmem_En, MEMwb_En} = en_c;
  assign {IFid_Flush, IDex_Flush, EXmem_Flush}         = flush_c;
  assign PC_Src      = pc_src_c;
  assign Stalled     = stalled_c;
  assign Mem_Timeout = timeout_q;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stalled_c) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (|flush_c)  flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign Perf_Stall_Cnt = stall_cnt_q;
  assign Perf_Flush_Cnt = flush_cnt_q;
`else
  assign Perf_Stall_Cnt = '0;
  assign Perf_Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (timeout 255 and 3) against a behavioural model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, need, br, jmp, req, rdy, halt, resume;

  logic pc_en_0, ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0;
  logic ifid_fl_0, idex_fl_0, exmem_fl_0, stalled_0, to_0;
  logic [1:0] pc_src_0;
  logic [31:0] ps_0, pf_0;
  logic pc_en_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1;
  logic ifid_fl_1, idex_fl_1, exmem_fl_1, stalled_1, to_1;
  logic [1:0] pc_src_1;
  logic [31:0] ps_1, pf_1;

  pipe_ctrl #(.MEM_TIMEOUT(255)) u_dut0 (
    .clk(clk), .rst(rst), .Need_Stall(need), .EX__Branch_Taken(br), .ID__Jump(jmp),
    .MEM__Req(req), .MEM__Ready(rdy), .WB__Halt(halt), .Resume(resume),
    .PC_En(pc_en_0), .IFid_En(ifid_en_0), .IDex_En(idex_en_0), .EXmem_En(exmem_en_0),
    .MEMwb_En(memwb_en_0), .IFid_Flush(ifid_fl_0), .IDex_Flush(idex_fl_0),
    .EXmem_Flush(exmem_fl_0), .PC_Src(pc_src_0), .Stalled(stalled_0),
    .Mem_Timeout(to_0), .Perf_Stall_Cnt(ps_0), .Perf_Flush_Cnt(pf_0));

  pipe_ctrl #(.MEM_TIMEOUT(3)) u_dut1 (
    .clk(clk), .rst(rst), .Need_Stall(need), .EX__Branch_Taken(br), .ID__Jump(jmp),
    .MEM__Req(req), .MEM__Ready(rdy), .WB__Halt(halt), .Resume(resume),
    .PC_En(pc_en_1), .IFid_En(ifid_en_1), .IDex_En(idex_en_1), .EXmem_En(exmem_en_1),
    .MEMwb_En(memwb_en_1), .IFid_Flush(ifid_fl_1), .IDex_Flush(idex_fl_1),
    .EXmem_Flush(exmem_fl_1), .PC_Src(pc_src_1), .Stalled(stalled_1),
    .Mem_Timeout(to_1), .Perf_Stall_Cnt(ps_1), .Perf_Flush_Cnt(pf_1));

  // Packed view: {PC,IFid,IDex,EXmem,MEMwb enables, IFid,IDex,EXmem flushes, PC_Src, Stalled}
  logic [10:0] ctrl_0, ctrl_1;
  assign ctrl_0 = {pc_en_0, ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0,
                   ifid_fl_0, idex_fl_0, exmem_fl_0, pc_src_0, stalled_0};
  assign ctrl_1 = {pc_en_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1,
                   ifid_fl_1, idex_fl_1, exmem_fl_1, pc_src_1, stalled_1};

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  int          lim[2] = '{255, 3};
  bit          m_halt[2], m_wait[2], m_to[2];
  int          m_waits[2];
  logic [31:0] m_ps[2], m_pf[2];

  function automatic logic [10:0] exp_ctrl(int k);
    logic [4:0] en;
    logic [2:0] fl;
    logic [1:0] src;
    bit         frozen;
    en = 5'b11111; fl = 3'b000; src = 2'b00;
    if (!rst) return 11'd0;
    frozen = m_halt[k] || (m_wait[k] && !rdy) || halt || (!m_wait[k] && req && !rdy);
    if (frozen)          en = 5'b00000;
    else if (need)       begin en = 5'b00011; fl = 3'b001; end
    else if (br)         begin src = 2'b10; fl = 3'b110; end
    else if (jmp)        begin src = 2'b01; fl = 3'b100; end
    if (m_halt[k] || (m_wait[k] && !rdy)) begin fl = 3'b000; src = 2'b00; end
    return {en, fl, src, (en != 5'b11111)};
  endfunction

  task automatic model_tick();
    logic [10:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_ctrl(k);
      if (!rst) begin
        m_halt[k] = 0; m_wait[k] = 0; m_to[k] = 0; m_waits[k] = 0;
        m_ps[k] = '0; m_pf[k] = '0;
      end else begin
        if (e[0])    m_ps[k] = m_ps[k] + 32'd1;
        if (|e[5:3]) m_pf[k] = m_pf[k] + 32'd1;
        if (m_halt[k]) begin
          if (resume) begin m_halt[k] = 0; m_to[k] = 0; end
        end else if (m_wait[k] && !rdy) begin
          m_waits[k]++;
          if (m_waits[k] == lim[k]) begin m_halt[k] = 1; m_wait[k] = 0; m_to[k] = 1; end
        end else if (halt) begin
          m_halt[k] = 1; m_wait[k] = 0;
        end else if (!m_wait[k] && req && !rdy) begin
          m_wait[k] = 1; m_waits[k] = 0;
        end else begin
          m_wait[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] eps, epf;
    for (int k = 0; k < 2; k++) begin
`ifdef PIPE_PERF_EN
      eps = m_ps[k]; epf = m_pf[k];
`else
      eps = '0; epf = '0;
`endif
      chk($sformatf("ctrl%0d", k), 32'(k == 0 ? ctrl_0 : ctrl_1), 32'(exp_ctrl(k)));
      chk($sformatf("timeout%0d", k), 32'(k == 0 ? to_0 : to_1), 32'(m_to[k]));
      chk($sformatf("perf_stall%0d", k), k == 0 ? ps_0 : ps_1, eps);
      chk($sformatf("perf_flush%0d", k), k == 0 ? pf_0 : pf_1, epf);
    end
  endtask

  // Drive inputs after the falling edge and compare before the next rising edge
  task automatic apply(input logic r, input logic ns, input logic b, input logic j,
                       input logic rq, input logic rd, input logic h, input logic rs);
    @(negedge clk);
    rst = r; need = ns; br = b; jmp = j; req = rq; rdy = rd; halt = h; resume = rs;
    #1;
    check_all();
  endtask

  task automatic clock();
    @(posedge clk);
    model_tick();
  endtask

  localparam logic [10:0] C_RESET  = 11'b00000_000_00_0;
  localparam logic [10:0] C_IDLE   = 11'b11111_000_00_0;
  localparam logic [10:0] C_FROZEN = 11'b00000_000_00_1;
  localparam logic [10:0] C_LDUSE  = 11'b00011_001_00_1;
  localparam logic [10:0] C_BRANCH = 11'b11111_110_10_0;

  initial begin
    rst = 0; need = 1; br = 0; jmp = 0; req = 0; rdy = 0; halt = 0; resume = 0;
    for (int k = 0; k < 2; k++) begin
      m_halt[k] = 0; m_wait[k] = 0; m_to[k] = 0; m_waits[k] = 0; m_ps[k] = '0; m_pf[k] = '0;
    end

    // Reset held with a pending load-use request
    repeat (3) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0);
      chk("reset_ctrl", 32'(ctrl_0), 32'(C_RESET));
      clock();
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset", 32'(ctrl_0), 32'(C_IDLE));
    clock();

    // Load-use bubble
    apply(1, 1, 0, 0, 0, 0, 0, 0);
    chk("load_use", 32'(ctrl_0), 32'(C_LDUSE));
    clock();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    chk("load_use_after", 32'(ctrl_0), 32'(C_IDLE));
    clock();

    // Branch beats jump
    apply(1, 0, 1, 1, 0, 0, 0, 0);
    chk("branch_jump", 32'(ctrl_0), 32'(C_BRANCH));
    clock();

    // Memory wait of four frozen cycles, completing with a taken branch
    apply(0, 0, 0, 0, 0, 0, 0, 0); clock();
    repeat (4) begin
      apply(1, 0, 0, 0, 1, 0, 0, 0);
      chk("mwait_frozen", 32'(ctrl_0), 32'(C_FROZEN));
      clock();
    end
    apply(1, 0, 1, 0, 1, 1, 0, 0);
    chk("mwait_ready_branch", 32'(ctrl_0), 32'(C_BRANCH));
    chk("t3_halted_frozen", 32'(ctrl_1), 32'(C_FROZEN));
    clock();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_PERF_EN
    chk("perf_stall_4", ps_0, 32'd4);
    chk("perf_flush_1", pf_0, 32'd1);
`endif
    clock();

    // Timeout with limit 3 on instance 1
    apply(0, 0, 0, 0, 0, 0, 0, 0); clock();
    repeat (4) begin apply(1, 0, 0, 0, 1, 0, 0, 0); clock(); end
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_set", 32'(to_1), 32'd1);
    chk("timeout_halt", 32'(ctrl_1), 32'(C_FROZEN));
    chk("no_timeout_255", 32'(to_0), 32'd0);
    clock();
    apply(1, 0, 0, 0, 0, 0, 0, 1);
    chk("resume_cycle", 32'(ctrl_1), 32'(C_FROZEN));
    clock();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_clear", 32'(to_1), 32'd0);
    chk("resumed_run", 32'(ctrl_1), 32'(C_IDLE));
    clock();

    // Halt wins over load-use and holds until resume
    apply(0, 0, 0, 0, 0, 0, 0, 0); clock();
    apply(1, 1, 0, 0, 0, 0, 1, 0);
    chk("halt_over_stall", 32'(ctrl_0), 32'(C_FROZEN));
    clock();
    repeat (2) begin
      apply(1, 1, 1, 0, 0, 0, 1, 0);
      chk("halt_hold", 32'(ctrl_0), 32'(C_FROZEN));
      clock();
    end
    apply(1, 0, 0, 0, 0, 0, 0, 1); clock();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_resumed", 32'(ctrl_0), 32'(C_IDLE));
    clock();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 63) != 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) == 0);
      clock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
